// File: rtl/ddram_port_arbiter_if.sv
// Signal bundle between the DDRAM port arbiter, its two requesters and the ddram buffer.
// The slave modport is the arbiter's view; master is the environment (requesters plus memory).
interface ddram_port_arbiter_if #(
   parameter int AW = 27
);
   logic          p0_req;
   logic          p0_we;
   logic [AW-1:0] p0_addr;
   logic [7:0]    p0_din;
   logic [7:0]    p0_dout;
   logic          p0_ack;

   logic          p1_req;
   logic          p1_we;
   logic [AW-1:0] p1_addr;
   logic [7:0]    p1_din;
   logic [7:0]    p1_dout;
   logic          p1_ack;

   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          mem_we;
   logic          mem_rd;
   logic [7:0]    mem_dout;
   logic          mem_ready;

   logic [1:0]    grant;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_din,
      output p0_dout, p0_ack,
      input  p1_req, p1_we, p1_addr, p1_din,
      output p1_dout, p1_ack,
      output mem_addr, mem_din, mem_we, mem_rd,
      input  mem_dout, mem_ready,
      output grant
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_din,
      input  p0_dout, p0_ack,
      output p1_req, p1_we, p1_addr, p1_din,
      input  p1_dout, p1_ack,
      input  mem_addr, mem_din, mem_we, mem_rd,
      output mem_dout, mem_ready,
      input  grant
   );
endinterface

// File: rtl/ddram_port_arbiter.sv
// Two-port arbiter for the byte-wide DDRAM buffer (loader = port 0, tape playback = port 1).
// Define DDRAM_ARB_FIXED_PRIO_EN to give port 0 absolute priority instead of round-robin.
module ddram_port_arbiter #(
   parameter int AW        = 27,
   parameter int BUSY_WAIT = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   ddram_port_arbiter_if.slave  bus
);

   localparam int WDW = (BUSY_WAIT < 1) ? 1 : $clog2(BUSY_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [AW-1:0]  mem_addr_q;
   logic [7:0]     mem_din_q;
   logic           we_q;
   logic [1:0]     grant_q;
   logic           busy_seen;
   logic [WDW-1:0] wdog;
   logic [7:0]     p0_dout_q;
   logic [7:0]     p1_dout_q;

   logic           acc_start;
   logic           complete;
   logic           pick_p1;
   logic           mem_we_c;
   logic           mem_rd_c;
   logic           p0_ack_c;
   logic           p1_ack_c;

`ifdef DDRAM_ARB_FIXED_PRIO_EN
   // Loader always wins a tie; port 1 only gets the bus when port 0 is quiet.
   assign pick_p1 = ~bus.p0_req;
`else
   logic           last_p1;

   // On a tie the port that did not own the previous access goes next.
   assign pick_p1 = bus.p1_req & (~bus.p0_req | ~last_p1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_p1 <= 1'b1;
      end else if (state == DONE) begin
         last_p1 <= grant_q[1];
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_start = 1'b0;
      complete  = 1'b0;
      mem_we_c  = 1'b0;
      mem_rd_c  = 1'b0;
      p0_ack_c  = 1'b0;
      p1_ack_c  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.mem_ready && (bus.p0_req || bus.p1_req)) begin
               acc_start = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            mem_we_c  = we_q;
            mem_rd_c  = ~we_q;
            state_nxt = WAIT;
         end
         WAIT: begin
            // A memory that never drops ready is treated as done once the watchdog expires.
            if (bus.mem_ready && (busy_seen || wdog == '0)) begin
               complete  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            p0_ack_c  = grant_q[0];
            p1_ack_c  = grant_q[1];
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // --- access latch: captured once at the winning edge, held until the next win
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         we_q       <= 1'b0;
         grant_q    <= 2'b00;
      end else if (acc_start) begin
         if (pick_p1) begin
            mem_addr_q <= bus.p1_addr;
            mem_din_q  <= bus.p1_din;
            we_q       <= bus.p1_we;
            grant_q    <= 2'b10;
         end else begin
            mem_addr_q <= bus.p0_addr;
            mem_din_q  <= bus.p0_din;
            we_q       <= bus.p0_we;
            grant_q    <= 2'b01;
         end
      end else if (state == DONE) begin
         grant_q <= 2'b00;
      end
   end

   // --- completion tracking: busy window detection and zero-latency watchdog
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_seen <= 1'b0;
         wdog      <= '0;
      end else if (state == ISSUE) begin
         busy_seen <= 1'b0;
         wdog      <= WDW'(BUSY_WAIT);
      end else if (state == WAIT) begin
         if (!bus.mem_ready) begin
            busy_seen <= 1'b1;
         end
         if (wdog != '0) begin
            wdog <= wdog - WDW'(1);
         end
      end
   end

   // --- read return: only the owning port's data register moves, and only on reads
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p0_dout_q <= '0;
         p1_dout_q <= '0;
      end else if (complete && !we_q) begin
         if (grant_q[0]) begin
            p0_dout_q <= bus.mem_dout;
         end
         if (grant_q[1]) begin
            p1_dout_q <= bus.mem_dout;
         end
      end
   end

   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign bus.mem_we   = mem_we_c;
   assign bus.mem_rd   = mem_rd_c;
   assign bus.grant    = grant_q;
   assign bus.p0_ack   = p0_ack_c;
   assign bus.p1_ack   = p1_ack_c;
   assign bus.p0_dout  = p0_dout_q;
   assign bus.p1_dout  = p1_dout_q;

endmodule
